// File: rtl/case_7_mul_pkg.sv
// Shared definitions for the pipelined saturating multiplier.
// Mode encoding and range-bound helpers used by the clamp stage.
package case_7_mul_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    // Bounds are returned as 64-bit two's complement patterns.
    function automatic logic [63:0] smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int w);
        return ~smax(w);
    endfunction

    function automatic logic [63:0] umax(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/case_7_mul_clamp.sv
// Overflow detection and optional clamping of a full-width product.
// Purely combinational; the caller registers its outputs.
module case_7_mul_clamp
    import case_7_mul_pkg::*;
#(
    parameter int PW = 16,
    parameter int W  = 10
) (
    input  logic [PW-1:0] p,
    input  logic          is_signed,
    input  logic          sat_en,
    output logic [W-1:0]  dout,
    output logic          ovf
);

    localparam logic [63:0] SMAX = smax(W);
    localparam logic [63:0] SMIN = smin(W);
    localparam logic [63:0] UMAX = umax(W);

    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic               ovf_s;
    logic               ovf_u;
    logic               sgn;
    logic               neg;

    always_comb begin
        ps    = 64'($signed(p));
        pu    = 64'(p);
        sgn   = (mode_e'(is_signed) == MODE_SIGNED);
        neg   = p[PW-1];
        ovf_s = (ps > $signed(SMAX)) || (ps < $signed(SMIN));
        ovf_u = (pu > UMAX);
        ovf   = sgn ? ovf_s : ovf_u;
        dout  = p[W-1:0];
        unique case (1'b1)
            sat_en && ovf && sgn && neg:  dout = SMIN[W-1:0];
            sat_en && ovf && sgn && !neg: dout = SMAX[W-1:0];
            sat_en && ovf && !sgn:        dout = UMAX[W-1:0];
            default:                      dout = p[W-1:0];
        endcase
    end

endmodule

// File: rtl/case_7_mul_pipe_sat.sv
// Pipelined signed/unsigned multiplier with stall-all valid/ready flow.
// Product registered in stage 0, clamp decision registered in the last stage.
module case_7_mul_pipe_sat
    import case_7_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 10,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    input  logic                  sat_en,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    logic          advance;
    logic          take;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;

    assign advance  = ce & ~ap_rst & (~out_valid | out_ready);
    assign in_ready = advance;
    assign take     = in_valid & advance;

    // Extending both operands to PW bits makes the low PW bits exact in either mode.
    always_comb begin
        a_ext = PW'(din0);
        b_ext = PW'(din1);
        if (is_signed) begin
            a_ext = PW'($signed(din0));
            b_ext = PW'($signed(din1));
        end
        prod = a_ext * b_ext;
    end

    if (NUM_STAGE == 1) begin : g_one
        logic [dout_WIDTH-1:0] c_dout;
        logic                  c_ovf;

        case_7_mul_clamp #(
            .PW (PW),
            .W  (dout_WIDTH)
        ) u_clamp (
            .p         (prod),
            .is_signed (is_signed),
            .sat_en    (sat_en),
            .dout      (c_dout),
            .ovf       (c_ovf)
        );

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                out_valid <= 1'b0;
                dout      <= '0;
                ovf       <= 1'b0;
                tag_out   <= '0;
            end else if (advance) begin
                out_valid <= take;
                dout      <= c_dout;
                ovf       <= c_ovf;
                tag_out   <= tag_in;
            end
        end
    end else begin : g_multi
        localparam int L = NUM_STAGE - 1;

        logic [L-1:0]          vld;
        logic [L-1:0]          sat;
        logic [PW-1:0]         prd [L];
        mode_e                 md  [L];
        logic [TAG_WIDTH-1:0]  tg  [L];
        logic [dout_WIDTH-1:0] c_dout;
        logic                  c_ovf;

        case_7_mul_clamp #(
            .PW (PW),
            .W  (dout_WIDTH)
        ) u_clamp (
            .p         (prd[L-1]),
            .is_signed (md[L-1] == MODE_SIGNED),
            .sat_en    (sat[L-1]),
            .dout      (c_dout),
            .ovf       (c_ovf)
        );

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                vld <= '0;
                sat <= '0;
                for (int i = 0; i < L; i++) begin
                    prd[i] <= '0;
                    md[i]  <= MODE_UNSIGNED;
                    tg[i]  <= '0;
                end
                out_valid <= 1'b0;
                dout      <= '0;
                ovf       <= 1'b0;
                tag_out   <= '0;
            end else if (advance) begin
                vld[0] <= take;
                sat[0] <= sat_en;
                prd[0] <= prod;
                md[0]  <= mode_e'(is_signed);
                tg[0]  <= tag_in;
                for (int i = 1; i < L; i++) begin
                    vld[i] <= vld[i-1];
                    sat[i] <= sat[i-1];
                    prd[i] <= prd[i-1];
                    md[i]  <= md[i-1];
                    tg[i]  <= tg[i-1];
                end
                out_valid <= vld[L-1];
                dout      <= c_dout;
                ovf       <= c_ovf;
                tag_out   <= tg[L-1];
            end
        end
    end

endmodule

// File: tb/tb_case_7_mul_pipe_sat.sv
// Randomised and directed bench for case_7_mul_pipe_sat.
// Three instances (1, 2 and 4 stages) share stimulus; each has its own model queue.
module tb_case_7_mul_pipe_sat;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int DW = 10;
    localparam int TW = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          o;
        logic [TW-1:0] t;
        int            adv;
        bit            hw;
        logic [DW-1:0] wd;
        logic          wo;
    } ent_t;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          ce   = 1'b1;
    logic          iv   = 1'b0;
    logic          ordy = 1'b1;
    logic          sg   = 1'b0;
    logic          st   = 1'b0;
    logic [AW-1:0] a    = '0;
    logic [BW-1:0] b    = '0;
    logic [TW-1:0] tg   = '0;
    bit            hw   = 1'b0;
    logic [DW-1:0] wd   = '0;
    logic          wo   = 1'b0;
    bit            fin  = 1'b0;

    logic [2:0]    ir;
    logic [2:0]    ov;
    logic [2:0]    of;
    logic [DW-1:0] dd [3];
    logic [TW-1:0] to [3];

    int nchk = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer product, range test and clamp.
    function automatic ent_t model(input logic [AW-1:0] x,
                                   input logic [BW-1:0] y,
                                   input logic s, input logic t,
                                   input logic [TW-1:0] k);
        ent_t   e;
        longint xv, yv, p, r, lo, hi, um;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        p  = xv * yv;
        lo = -(longint'(1) << (DW - 1));
        hi = (longint'(1) << (DW - 1)) - 1;
        um = (longint'(1) << DW) - 1;
        e.o = s ? (p < lo || p > hi) : (p > um);
        r = p;
        if (t && e.o) r = s ? ((p < 0) ? lo : hi) : um;
        e.d   = DW'(r);
        e.t   = k;
        e.adv = 0;
        e.hw  = 1'b0;
        e.wd  = '0;
        e.wo  = 1'b0;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        case_7_mul_pipe_sat #(
            .ID         (g),
            .NUM_STAGE  (NS),
            .din0_WIDTH (AW),
            .din1_WIDTH (BW),
            .dout_WIDTH (DW),
            .TAG_WIDTH  (TW)
        ) u_dut (
            .ap_clk    (clk),
            .ap_rst    (rst),
            .ce        (ce),
            .in_valid  (iv),
            .in_ready  (ir[g]),
            .din0      (a),
            .din1      (b),
            .is_signed (sg),
            .sat_en    (st),
            .tag_in    (tg),
            .out_valid (ov[g]),
            .out_ready (ordy),
            .dout      (dd[g]),
            .ovf       (of[g]),
            .tag_out   (to[g])
        );

        ent_t          q[$];
        int            adv  = 0;
        bit            seen = 1'b0;
        bit            ph   = 1'b0;
        logic          pv;
        logic          po;
        logic [DW-1:0] pd;
        logic [TW-1:0] pt;

        always @(negedge clk) begin : sb
            ent_t  e;
            string s;
            s = $sformatf("ns%0d", NS);
            if (fin) chk({s, " drained"}, 64'(q.size()), 0);
            if (rst) begin
                chk({s, " rdy_rst"}, ir[g], 0);
                q.delete();
                seen = 1'b0;
                ph   = 1'b0;
            end else begin
                if (ph) begin
                    chk({s, " hold_v"}, ov[g], pv);
                    chk({s, " hold_d"}, dd[g], pd);
                    chk({s, " hold_o"}, of[g], po);
                    chk({s, " hold_t"}, to[g], pt);
                end
                chk({s, " rdy"}, ir[g], ce & (~ov[g] | ordy));
                if (ov[g]) begin
                    chk({s, " stale"}, q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q[0];
                        if (!seen) begin
                            chk({s, " lat"}, 64'(adv - e.adv), 64'(NS));
                            seen = 1'b1;
                        end
                        if (ce && ordy) begin
                            chk({s, " dout"}, dd[g], e.d);
                            chk({s, " ovf"}, of[g], e.o);
                            chk({s, " tag"}, to[g], e.t);
                            if (e.hw) begin
                                chk({s, " dout_plan"}, dd[g], e.wd);
                                chk({s, " ovf_plan"}, of[g], e.wo);
                            end
                            void'(q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
                if (iv && ir[g]) begin
                    e     = model(a, b, sg, st, tg);
                    e.adv = adv;
                    e.hw  = hw;
                    e.wd  = wd;
                    e.wo  = wo;
                    q.push_back(e);
                end
                if (ir[g]) adv++;
                ph = (ov[g] && !ordy) || !ce;
                pv = ov[g];
                pd = dd[g];
                po = of[g];
                pt = to[g];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic put(input int x, input int y, input logic s,
                       input logic t, input int k, input bit h,
                       input int w, input logic v);
        a  = AW'(x);
        b  = BW'(y);
        sg = s;
        st = t;
        tg = TW'(k);
        hw = h;
        wd = DW'(w);
        wo = v;
        iv = 1'b1;
        step();
        iv = 1'b0;
        hw = 1'b0;
    endtask

    task automatic rnd_ops();
        a  = AW'($urandom);
        b  = BW'($urandom);
        sg = 1'($urandom);
        st = 1'($urandom);
        tg = TW'($urandom);
    endtask

    initial begin
        int pat [4];
        pat = '{1, 0, 0, 1};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset ov%0d", g), ov[g], 0);
            chk($sformatf("reset dout%0d", g), dd[g], 0);
            chk($sformatf("reset ovf%0d", g), of[g], 0);
            chk($sformatf("reset tag%0d", g), to[g], 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        put(10, -5, 1, 0, 3, 1, 'h3CE, 0);
        idle(6);
        put(127, 127, 1, 1, 1, 1, 'h1FF, 1);
        put(-128, -128, 1, 1, 2, 1, 'h1FF, 1);
        put(-128, 127, 1, 1, 4, 1, 'h200, 1);
        put(127, 127, 1, 0, 5, 1, 'h301, 1);
        put(255, 255, 0, 1, 6, 1, 'h3FF, 1);
        put(20, 30, 0, 1, 7, 1, 'h258, 0);
        idle(6);

        for (int i = 0; i < 16; i++) begin
            rnd_ops();
            tg   = TW'(i);
            iv   = (i < 8);
            ordy = pat[i % 4][0];
            ce   = !(i >= 5 && i < 8);
            step();
        end
        iv   = 1'b0;
        ce   = 1'b1;
        ordy = 1'b1;
        idle(8);

        put(3, 4, 0, 0, 8, 0, 0, 0);
        put(-7, 9, 1, 1, 9, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++)
            chk($sformatf("midrst ov%0d", g), ov[g], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);

        for (int i = 0; i < 400; i++) begin
            rnd_ops();
            iv   = 1'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            ce   = ($urandom_range(0, 7) != 0);
            step();
        end
        iv   = 1'b0;
        ce   = 1'b1;
        ordy = 1'b1;
        idle(10);

        fin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/case_7_mul_pipe_sat.md
Name: case_7_mul_pipe_sat

Overview:
- Parametrised, pipelined multiplier with valid/ready flow control, per-transaction signed/unsigned selection, optional saturation and an overflow flag.
- Successor to the fixed combinational `case_7_mul_*` operator cores.
- Sits between HLS datapath stages that need registered multiplies under backpressure.
- A tag travels with each operand pair so downstream logic can re-associate results.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 2, pipeline register stages from input accept to output valid; legal range 1..8.
- din0_WIDTH, 8, operand A width.
- din1_WIDTH, 8, operand B width.
- dout_WIDTH, 10, result width; any value 2..(din0_WIDTH+din1_WIDTH).
- TAG_WIDTH, 4, sideband tag width; must be 1 or more.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; when 0, all pipeline state freezes.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- is_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- sat_en  in  1  1 = clamp to dout range; 0 = keep low dout_WIDTH bits.
- tag_in  in  TAG_WIDTH  sideband carried with the pair.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- dout  out  dout_WIDTH  result.
- ovf  out  1  full product did not fit in dout_WIDTH under the transaction's mode.
- tag_out  out  TAG_WIDTH  tag of the current result.

Behaviour:
- Reset (ap_rst=1 at an edge):
  - All stage valid bits clear; out_valid=0, dout=0, ovf=0, tag_out=0.
  - in_ready is low during the reset cycle.
  - Reset mid-operation discards all in-flight transactions; no partial outputs afterwards.
- Advance condition: advance = ce & ~ap_rst & (~out_valid | out_ready). This is a stall-all pipeline.
  - in_ready = advance, combinational.
  - A pair is accepted when in_valid & in_ready.
- Pipeline timing:
  - On advance, every stage shifts by one. Stage 0 loads the valid bit (in_valid & in_ready), operands, mode bits and tag.
  - Bubbles propagate as invalid stages. There is no bubble collapse.
- Latency:
  - A pair accepted at edge k produces out_valid=1 after edge k+NUM_STAGE-1, provided there was no stall.
  - Each stall cycle adds one cycle.
  - Throughput is one result per cycle when out_ready=1 continuously.
- Hold rule: while out_valid=1 and out_ready=0, dout, ovf and tag_out hold stable. When ce=0, everything holds regardless of out_ready.
- Arithmetic: full product P has width din0_WIDTH+din1_WIDTH.
  - Signed mode: both operands sign-extended.
  - Unsigned mode: both operands zero-extended.
- Overflow test:
  - Signed mode: P outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - Unsigned mode: P > 2^dout_WIDTH - 1.
- Result selection:
  - sat_en=1 and overflow: dout = nearest bound. Signed mode gives max 0x1FF or min 0x200 for W=10; unsigned mode gives all ones.
  - Otherwise: dout = P[dout_WIDTH-1:0].
  - ovf reports the overflow test independently of sat_en.
- Stage placement:
  - Multiplication is registered in the first stage.
  - The overflow/clamp decision is registered in the final stage.
  - For NUM_STAGE=1, both happen in the single stage.
- Simultaneous accept and drain at full occupancy is legal every cycle; there is no loss and no duplication.

Decomposition:
- Shared package `case_7_mul_pkg`:
  - Mode encodings MODE_UNSIGNED=0 and MODE_SIGNED=1.
  - Functions returning the signed max, signed min and unsigned max for a given width.
- One sub-module, `case_7_mul_clamp`:
  - Combinational.
  - Takes the full product, is_signed and sat_en.
  - Returns dout and ovf.
  - Instantiated in the final stage.

Test Plan (din0_WIDTH=8, din1_WIDTH=8, dout_WIDTH=10, NUM_STAGE=2 unless stated):
1. Signed, no overflow, no saturation. 10 × -5 with tag 3 -> dout=0x3CE, ovf=0, tag_out=3, out_valid exactly 2 cycles after accept.
2. Signed, saturating. 127×127 -> 0x1FF with ovf=1; -128×-128 -> 0x1FF with ovf=1; -128×127 -> 0x200 with ovf=1.
3. Signed, truncating (sat_en=0). 127×127 -> 0x301 with ovf=1.
4. Unsigned, saturating (is_signed=0, sat_en=1). 255×255 -> 0x3FF with ovf=1; 20×30 -> 0x258 with ovf=0.
5. Backpressure: stream 8 pairs while out_ready toggles 1,0,0,1.
   - Results arrive in order with matching tags, none dropped or duplicated.
   - dout stays stable while stalled; ce=0 for 3 cycles freezes all state.
6. Reset and stage count: assert ap_rst with 2 pairs in flight.
   - Next cycle out_valid=0 and no stale results appear afterwards.
   - Repeat scenarios 1 and 5 with NUM_STAGE=1 and NUM_STAGE=4.
